// File: rtl/spi_master_ctrl.sv
// SPI master (mode 0, MSB first, one byte per transfer) behind a 4-register
// byte-wide IO window. Software writes TXDATA, CTRL and CMD. It reads back RX,
// CTRL and status. A level interrupt is raised when a transfer completes.
module spi_master_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       io_wr_ni,
    input  logic [7:0] io_addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] rd_data_o,
    output logic       irq_o,
    output logic       spi_clk,
    output logic       mosi,
    input  logic       miso,
    output logic [2:0] spi_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD
    } state_t;

    state_t     state;
    logic       wr_prev;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] txsr;
    logic [7:0] rxsr;
    logic [2:0] dev;
    logic       irq_en;
    logic [3:0] div;
    logic [3:0] hp;
    logic [2:0] bc;
    logic       busy;
    logic       done;
    logic       ovr;

    logic       sel;
    logic       wr_acc;
    logic       wr_tx;
    logic       wr_ctrl;
    logic       wr_cmd;
    logic       cmd_clr;
    logic       cmd_start;
    logic       start_ok;
    logic       ovr_hit;
    logic       hp_end;

    // A held-low strobe counts once: only the high-to-low step is a write.
    assign sel       = (io_addr_i[7:2] == BASE_ADDR[7:2]);
    assign wr_acc    = ~io_wr_ni & wr_prev & sel;
    assign wr_tx     = wr_acc & (io_addr_i[1:0] == 2'd0);
    assign wr_ctrl   = wr_acc & (io_addr_i[1:0] == 2'd1);
    assign wr_cmd    = wr_acc & (io_addr_i[1:0] == 2'd2);
    assign cmd_clr   = wr_cmd & data_i[1];
    assign cmd_start = wr_cmd & data_i[0];
    assign start_ok  = cmd_start & ~busy & (dev != 3'd0);
    assign ovr_hit   = busy & (wr_tx | wr_ctrl | cmd_start);
    assign hp_end    = (hp == div);

    assign irq_o = done & irq_en;

    // Remember the previous strobe level for edge detection.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_prev <= 1'b1;
        end else begin
            wr_prev <= io_wr_ni;
        end
    end

    // Software-visible configuration; frozen while a transfer is running.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tx     <= 8'h00;
            dev    <= 3'd0;
            irq_en <= 1'b0;
            div    <= 4'd0;
        end else begin
            if (wr_tx && !busy) begin
                tx <= data_i;
            end
            if (wr_ctrl && !busy) begin
                div    <= data_i[7:4];
                irq_en <= data_i[3];
                dev    <= data_i[2:0];
            end
        end
    end

    // Transfer sequencer with flags and registered SPI pins.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= S_IDLE;
            hp       <= 4'd0;
            bc       <= 3'd0;
            txsr     <= 8'h00;
            rxsr     <= 8'h00;
            rx       <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovr      <= 1'b0;
            spi_clk  <= 1'b0;
            mosi     <= 1'b0;
            spi_addr <= 3'd0;
        end else begin
            // Clear is applied before a rejected start can flag an overrun.
            if (cmd_clr) begin
                done <= 1'b0;
                ovr  <= 1'b0;
            end
            if (ovr_hit) begin
                ovr <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state    <= S_SETUP;
                        hp       <= 4'd0;
                        bc       <= 3'd0;
                        busy     <= 1'b1;
                        spi_addr <= dev;
                        txsr     <= tx;
                        mosi     <= tx[7];
                    end
                end

                S_SETUP: begin
                    if (hp_end) begin
                        state   <= S_HIGH;
                        hp      <= 4'd0;
                        spi_clk <= 1'b1;
                        rxsr    <= {rxsr[6:0], miso};
                    end else begin
                        hp <= hp + 4'd1;
                    end
                end

                S_HIGH: begin
                    if (hp_end) begin
                        hp      <= 4'd0;
                        spi_clk <= 1'b0;
                        if (bc == 3'd7) begin
                            // Last bit: mosi keeps its value through HOLD.
                            state <= S_HOLD;
                        end else begin
                            state <= S_LOW;
                            bc    <= bc + 3'd1;
                            txsr  <= {txsr[6:0], 1'b0};
                            mosi  <= txsr[6];
                        end
                    end else begin
                        hp <= hp + 4'd1;
                    end
                end

                S_LOW: begin
                    if (hp_end) begin
                        state   <= S_HIGH;
                        hp      <= 4'd0;
                        spi_clk <= 1'b1;
                        rxsr    <= {rxsr[6:0], miso};
                    end else begin
                        hp <= hp + 4'd1;
                    end
                end

                S_HOLD: begin
                    if (hp_end) begin
                        state    <= S_IDLE;
                        hp       <= 4'd0;
                        rx       <= rxsr;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        spi_addr <= 3'd0;
                        mosi     <= 1'b0;
                    end else begin
                        hp <= hp + 4'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-back mux, selected by the low address bits only.
    always_comb begin
        rd_data_o = 8'h00;
        case (io_addr_i[1:0])
            2'd0:    rd_data_o = rx;
            2'd1:    rd_data_o = {div, irq_en, dev};
            2'd2:    rd_data_o = {5'b00000, ovr, done, busy};
            default: rd_data_o = 8'h00;
        endcase
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Memory-mapped SPI master that sequences the processor's SPI port (`spi_clk`, `mosi`, `miso`, `spi_addr`) from the 8-bit uni-directional IO bus.
- Software configures it through byte-wide IO writes: device select, clock divider and interrupt enable.
- It loads a transmit byte, starts a transfer, then reads back status and the received byte.
- It runs SPI mode 0 (CPOL=0, CPHA=0), MSB first, one byte per transfer.
- It raises an interrupt line toward the processor's `irq_i` on completion.

## Interface
Parameters:
- `BASE_ADDR`, default 8'h00: IO base of the 4-register window; `io_addr_i[7:2]` must equal `BASE_ADDR[7:2]`.

Ports:
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `io_wr_ni`  in  1  IO write strobe, active low; a level that may be held for several cycles.
- `io_addr_i`  in  8  IO address.
- `data_i`  in  8  IO write data.
- `rd_data_o`  out  8  combinational read-back of the register selected by `io_addr_i[1:0]`.
- `irq_o`  out  1  level interrupt, equal to `done & irq_en`.
- `spi_clk`  out  1  SPI clock, idles 0.
- `mosi`  out  1  serial data to the slave.
- `miso`  in  1  serial data from the slave.
- `spi_addr`  out  3  device select; 0 means no device, 1..7 select a device through glue logic.

## Operation
Write acceptance:
- A write is accepted only in the first cycle that `io_wr_ni` is low after being high.
- The previous `io_wr_ni` value is registered; it resets to 1.
- The address must also match `BASE_ADDR`.

Write registers (`io_addr_i[1:0]`):
- 0 TXDATA: loads `tx`.
- 1 CTRL: [2:0] `dev`, [3] `irq_en`, [7:4] `div`.
- 2 CMD: bit1 clears `done` and `ovr`; bit0 starts a transfer.
- 3: ignored.

Read mux:
- 0 → `rx`.
- 1 → CTRL.
- 2 → {5'b0, `ovr`, `done`, `busy`}.
- 3 → 8'h00.

Busy and start rules:
- While `busy`=1, any accepted write to TXDATA or CTRL, or a CMD write with bit0 set, is ignored and sets `ovr`=1.
- A CMD bit1 clear is still honoured while busy.
- If a CMD write sets both bits, the clear happens first, then the start.
- A start with `dev`==0 is ignored and no flag changes.

FSM states: IDLE, SETUP, HIGH, LOW, HOLD.
- Every non-IDLE state lasts `div`+1 cycles, timed by a half-period counter that restarts on each state entry.
- IDLE → SETUP on an accepted start:
  - `busy`=1, `spi_addr`=`dev`.
  - `txsr`=`tx`, `mosi`=`tx[7]`, bit counter `bc`=0.
- SETUP → HIGH: `spi_clk`=1; `miso` is shifted into the LSB of `rxsr` on this transition.
- HIGH → LOW when `bc`<7:
  - `spi_clk`=0, `bc`+=1.
  - `mosi` = next bit (`txsr` shifted left).
- HIGH → HOLD when `bc`==7: `spi_clk`=0, `mosi` holds its value.
- LOW → HIGH: `spi_clk`=1, `miso` is sampled.
- HOLD → IDLE:
  - `rx`=`rxsr`, `done`=1, `busy`=0.
  - `spi_addr`=0, `mosi`=0.

Other behaviour:
- `tx` is not modified by a transfer.
- A new transfer does not clear `done`; only CMD bit1 clears it.

## Timing
- Reset values: `spi_clk`=0, `mosi`=0, `spi_addr`=0, `irq_o`=0.
- Register reset values: `tx`=`rx`=0, CTRL=8'h00 (`div`=0), `busy`=`done`=`ovr`=0.
- `rd_data_o` is the read mux with reset contents, i.e. 8'h00 for every address.
- Reset mid-transfer returns everything to the reset values immediately (asynchronous); no `done` is produced.
- Start latency: `busy` and `spi_addr` rise on the clock edge that accepts the CMD write.
- Transfer length is 17 half-periods (SETUP + 8 HIGH + 7 LOW + HOLD) = 17·(`div`+1) cycles from the accepting edge until `busy` falls.
- `div` ranges 0..15, giving half-periods of 1..16 cycles.
- `done`, `rx` and `irq_o` update on the same edge that `busy` falls.
- `irq_o` falls one edge after an accepted CMD bit1 write, or after a CTRL write with `irq_en`=0.
- Holding `io_wr_ni` low for N cycles counts as a single write; there is no spurious `ovr`.

## Test plan
- **Reset:** assert `reset_i`=0 mid-stream.
  - Required: all outputs at reset values.
  - Required: reading address 2 returns 8'h00.
- **Loopback, `div`=0:** `miso`=`mosi`; write CTRL=8'h03, TXDATA=8'hA5, CMD=8'h01.
  - Required: `busy` high exactly 17 cycles, `spi_addr`=3 throughout, 8 `spi_clk` rising edges.
  - Required: `rx`=8'hA5; status then reads 8'h02.
- **`div`=2, `miso`=1:** write CTRL=8'h21, TXDATA=8'h00, start.
  - Required: each `spi_clk` high/low phase lasts 3 cycles; `busy` lasts 51 cycles.
  - Required: `mosi` stays 0; `rx`=8'hFF.
- **Overrun:** during a busy transfer write TXDATA=8'h3C and CMD=8'h01.
  - Required: status reads 8'h05; `tx` is unchanged; the transfer completes normally; status reads 8'h06.
  - Then write CMD=8'h02 → status reads 8'h00.
- **Interrupt:** CTRL=8'h09, run a transfer.
  - Required: `irq_o`=1 on the edge `busy` falls.
  - Write CMD=8'h03 → `irq_o`=0 and a new transfer starts on the same edge.
- **Edge cases:**
  - Start with `dev`=0 → `busy` stays 0, no flag change.
  - `io_wr_ni` held low 5 cycles on CMD=8'h01 → exactly one transfer, `ovr`=0.
  - `reset_i` low during the 4th HIGH → immediate idle, `done`=0.
